// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache.
// Hits return the instruction combinationally in the same cycle. A miss stalls
// the fetch stage and refills the whole line, one word per memory ack, word 0 first.
// Optional build macro ICACHE_STATS_EN adds saturating hit and miss counters.
module icache_direct #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_chipEnable,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       o_inst,
  output logic              o_stall,
  output logic              o_memReq,
  output logic [ADDR_W-1:0] o_memAddr,
  input  logic              i_memAck,
  input  logic [31:0]       i_memData
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       o_hitCount,
  output logic [31:0]       o_missCount
`endif
);

  localparam int OFFB    = $clog2(LINE_WORDS);
  localparam int IDXB    = $clog2(SETS);
  localparam int TAG_LSB = 2 + OFFB + IDXB;
  localparam int TAGB    = ADDR_W - TAG_LSB;

  localparam logic [OFFB-1:0]   LAST_WORD  = OFFB'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  // Address fields of the current fetch
  logic [OFFB-1:0] off_w;
  logic [IDXB-1:0] idx_w;
  logic [TAGB-1:0] tag_w;

  assign off_w = i_addr[OFFB+1:2];
  assign idx_w = i_addr[OFFB+IDXB+1:OFFB+2];
  assign tag_w = i_addr[ADDR_W-1:TAG_LSB];

  // Byte-lane bits of the fetch address carry no information for word fetches
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^i_addr[1:0];

  // Storage: data and tag arrays are never reset; only valid bits are
  logic [31:0]     data_q   [SETS][LINE_WORDS];
  logic [TAGB-1:0] tagArr_q [SETS];
  logic [SETS-1:0] valid_q;

  // Control state
  state_t            state_q,   state_d;
  logic [OFFB-1:0]   cnt_q,     cnt_d;
  logic              memReq_q,  memReq_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [TAGB-1:0]   tagLat_q,  tagLat_d;
  logic [IDXB-1:0]   idxLat_q,  idxLat_d;

  logic hit;
  logic fillWe;
  logic lineDone;

  // Hit detection and the combinational fetch-side outputs
  always_comb begin
    hit     = i_chipEnable & valid_q[idx_w] & (tagArr_q[idx_w] == tag_w) & (state_q == IDLE);
    o_stall = i_chipEnable & ~hit;
    o_inst  = hit ? data_q[idx_w][off_w] : 32'h0;
  end

  assign o_memReq  = memReq_q;
  assign o_memAddr = memAddr_q;

  // Next-state logic: start a refill on a miss, walk the line word by word on acks
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    memReq_d  = memReq_q;
    memAddr_d = memAddr_q;
    tagLat_d  = tagLat_q;
    idxLat_d  = idxLat_q;
    fillWe    = 1'b0;
    lineDone  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_chipEnable && !hit) begin
          tagLat_d  = tag_w;
          idxLat_d  = idx_w;
          cnt_d     = '0;
          memReq_d  = 1'b1;
          memAddr_d = {tag_w, idx_w, {OFFB{1'b0}}, 2'b00};
          state_d   = REFILL;
        end
      end
      REFILL: begin
        memReq_d = 1'b1;
        if (i_memAck) begin
          fillWe = 1'b1;
          if (cnt_q != LAST_WORD) begin
            cnt_d     = cnt_q + OFFB'(1);
            memAddr_d = memAddr_q + WORD_BYTES;
          end else begin
            lineDone = 1'b1;
            memReq_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset aborts any refill in progress and invalidates every line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      memReq_q  <= 1'b0;
      memAddr_q <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      memReq_q  <= memReq_d;
      memAddr_q <= memAddr_d;
      if (lineDone) valid_q[idxLat_q] <= 1'b1;
    end
  end

  // Latched miss tag/index; only meaningful while a refill is in flight
  always_ff @(posedge clk) begin
    tagLat_q <= tagLat_d;
    idxLat_q <= idxLat_d;
  end

  // Line fill: write each acked word, commit the tag with the final word
  always_ff @(posedge clk) begin
    if (fillWe) data_q[idxLat_q][cnt_q] <= i_memData;
    if (lineDone) tagArr_q[idxLat_q] <= tagLat_q;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hitCount_q;
  logic [31:0] missCount_q;
  logic        missStart;

  assign missStart   = (state_q == IDLE) & i_chipEnable & ~hit;
  assign o_hitCount  = hitCount_q;
  assign o_missCount = missCount_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters: hit cycles and refill starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (hit)       hitCount_q  <= sat_inc(hitCount_q);
      if (missStart) missCount_q <= sat_inc(missCount_q);
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Testbench for icache_direct: randomized and directed fetch traffic checked
// against a line-level cache model backed by a fixed memory image.
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic        i_chipEnable;
  logic [31:0] i_addr;
  logic [31:0] o_inst;
  logic        o_stall;
  logic        o_memReq;
  logic [31:0] o_memAddr;
  logic        i_memAck;
  logic [31:0] i_memData;
`ifdef ICACHE_STATS_EN
  logic [31:0] o_hitCount;
  logic [31:0] o_missCount;
`endif

  icache_direct #(.ADDR_W(32), .LINE_WORDS(4), .SETS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_chipEnable (i_chipEnable),
    .i_addr       (i_addr),
    .o_inst       (o_inst),
    .o_stall      (o_stall),
    .o_memReq     (o_memReq),
    .o_memAddr    (o_memAddr),
    .i_memAck     (i_memAck),
    .i_memData    (i_memData)
`ifdef ICACHE_STATS_EN
    ,
    .o_hitCount   (o_hitCount),
    .o_missCount  (o_missCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which lines are resident, plus the refill in flight
  bit          mdl_valid [16];
  logic [31:0] mdl_tag   [16];
  bit          mdl_busy;
  logic [31:0] mdl_line;
  int          mdl_words;
  int unsigned mdl_hits;
  int unsigned mdl_misses;

  // Expected and observed values of the most recent cycle
  bit          exp_hit, exp_stall, exp_req;
  logic [31:0] exp_inst, exp_addr;
  logic        obs_stall, obs_req;
  logic [31:0] obs_inst, obs_addr;

  // Fixed external memory image
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mdl_valid[i] = 1'b0;
      mdl_tag[i]   = '0;
    end
    mdl_busy   = 1'b0;
    mdl_line   = '0;
    mdl_words  = 0;
    mdl_hits   = 0;
    mdl_misses = 0;
  endtask

  // Drive one fetch cycle starting at a falling edge, capture outputs, advance the model
  task automatic drive_cycle(input bit ce, input logic [31:0] a, input bit ack);
    int unsigned idx;
    logic [31:0] t;
    i_chipEnable = ce;
    i_addr       = a;
    i_memAck     = ack;
    i_memData    = ack ? memWord(o_memAddr) : $urandom;
    idx = (a / 16) % 16;
    t   = a / 256;
    exp_hit   = ce && !mdl_busy && mdl_valid[idx] && (mdl_tag[idx] == t);
    exp_stall = ce && !exp_hit;
    exp_inst  = exp_hit ? memWord(a - (a % 4)) : 32'h0;
    exp_req   = mdl_busy;
    exp_addr  = mdl_line + 32'(4 * mdl_words);
    #1;
    obs_stall = o_stall;
    obs_inst  = o_inst;
    obs_req   = o_memReq;
    obs_addr  = o_memAddr;
    @(posedge clk);
    if (exp_hit) mdl_hits++;
    if (mdl_busy) begin
      if (ack) begin
        mdl_words++;
        if (mdl_words == 4) begin
          mdl_valid[(mdl_line / 16) % 16] = 1'b1;
          mdl_tag[(mdl_line / 16) % 16]   = mdl_line / 256;
          mdl_busy = 1'b0;
        end
      end
    end else if (exp_stall) begin
      mdl_busy  = 1'b1;
      mdl_line  = a - (a % 16);
      mdl_words = 0;
      mdl_misses++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    i_chipEnable = 1'b0; i_addr = '0; i_memAck = 1'b0; i_memData = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_memReq !== 1'b0 || o_memAddr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem: req=%b addr=%h, wanted req=0 addr=00000000", o_memReq, o_memAddr);
    end
    n_checks++;
    if (o_stall !== 1'b0 || o_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_fetch_idle: stall=%b inst=%h, wanted 0 and 0", o_stall, o_inst);
    end
    i_chipEnable = 1'b1;
    #1;
    n_checks++;
    if (o_stall !== 1'b1 || o_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_all_invalid: stall=%b inst=%h, wanted stall=1 inst=0", o_stall, o_inst);
    end
    i_chipEnable = 1'b0;
`ifdef ICACHE_STATS_EN
    n_checks++;
    if (o_hitCount !== 32'h0 || o_missCount !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_stats: hit=%0d miss=%0d, wanted 0 and 0", o_hitCount, o_missCount);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    int stalls = 0;
    bit done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      drive_cycle(1'b1, 32'h0, 1'b1);
      n_checks++;
      if (obs_stall !== exp_stall || obs_req !== exp_req) begin
        n_fail++;
        $display("FAIL cold_ctrl cyc%0d: stall=%b req=%b, wanted stall=%b req=%b", c, obs_stall, obs_req, exp_stall, exp_req);
      end
      if (exp_req) begin
        n_checks++;
        if (obs_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL cold_memaddr cyc%0d: got %h, wanted %h", c, obs_addr, exp_addr);
        end
      end
      if (obs_stall === 1'b1) stalls++; else done = 1;
    end
    n_checks++;
    if (stalls != 5) begin
      n_fail++;
      $display("FAIL cold_stall_len: got %0d cycles, wanted 5", stalls);
    end
    n_checks++;
    if (obs_inst !== 32'h11) begin
      n_fail++;
      $display("FAIL cold_inst: got %h, wanted 00000011", obs_inst);
    end
  endtask

  task automatic test_line_hits();
    logic [31:0] want [3];
    want[0] = 32'h22; want[1] = 32'h33; want[2] = 32'h44;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 32'(4 * (k + 1)), 1'b0);
      n_checks++;
      if (obs_inst !== want[k] || obs_stall !== 1'b0 || obs_req !== 1'b0) begin
        n_fail++;
        $display("FAIL line_hit w%0d: inst=%h stall=%b req=%b, wanted inst=%h stall=0 req=0", k + 1, obs_inst, obs_stall, obs_req, want[k]);
      end
    end
`ifdef ICACHE_STATS_EN
    n_checks++;
    if (o_hitCount !== 32'd4 || o_missCount !== 32'd1) begin
      n_fail++;
      $display("FAIL stats_first: hit=%0d miss=%0d, wanted 4 and 1", o_hitCount, o_missCount);
    end
`endif
  endtask

  task automatic test_conflict();
    int stalls = 0;
    bit done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      drive_cycle(1'b1, 32'h100, 1'b1);
      if (exp_req) begin
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL conflict_req cyc%0d: req=%b addr=%h, wanted req=1 addr=%h", c, obs_req, obs_addr, exp_addr);
        end
      end
      if (obs_stall === 1'b1) stalls++; else done = 1;
    end
    n_checks++;
    if (stalls != 5 || obs_inst !== memWord(32'h100)) begin
      n_fail++;
      $display("FAIL conflict_fill: stalls=%0d inst=%h, wanted 5 and %h", stalls, obs_inst, memWord(32'h100));
    end
    drive_cycle(1'b1, 32'h0, 1'b0);
    n_checks++;
    if (obs_stall !== 1'b1 || obs_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL conflict_evict: stall=%b inst=%h, wanted stall=1 inst=0", obs_stall, obs_inst);
    end
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      drive_cycle(1'b1, 32'h0, 1'b1);
      if (obs_stall !== 1'b1) done = 1;
    end
    n_checks++;
    if (obs_inst !== 32'h11 || obs_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_refetch: inst=%h stall=%b, wanted 00000011 and 0", obs_inst, obs_stall);
    end
  endtask

  task automatic test_slow_mem();
    int stalls = 0;
    bit done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      drive_cycle(1'b1, 32'h48, (k > 0) && (k % 3 == 0));
      n_checks++;
      if (obs_stall !== exp_stall || obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
        n_fail++;
        $display("FAIL slow_cycle k%0d: stall=%b req=%b addr=%h, wanted stall=%b req=%b addr=%h", k, obs_stall, obs_req, obs_addr, exp_stall, exp_req, exp_addr);
      end
      if (obs_stall === 1'b1) stalls++; else done = 1;
    end
    n_checks++;
    if (stalls != 13) begin
      n_fail++;
      $display("FAIL slow_stall_len: got %0d cycles, wanted 13", stalls);
    end
    n_checks++;
    if (obs_inst !== memWord(32'h48)) begin
      n_fail++;
      $display("FAIL slow_inst: got %h, wanted %h", obs_inst, memWord(32'h48));
    end
  endtask

  task automatic test_reset_mid_refill();
    bit done = 0;
    drive_cycle(1'b1, 32'h200, 1'b0);
    drive_cycle(1'b1, 32'h200, 1'b1);
    drive_cycle(1'b1, 32'h200, 1'b1);
    rst = 1'b1;
    #1;
    n_checks++;
    if (o_memReq !== 1'b0 || o_memAddr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b addr=%h, wanted req=0 addr=00000000", o_memReq, o_memAddr);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(1'b1, 32'h0, 1'b0);
    n_checks++;
    if (obs_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_miss: stall=%b, wanted 1", obs_stall);
    end
    drive_cycle(1'b1, 32'h0, 1'b0);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_req: req=%b addr=%h, wanted req=1 addr=00000000", obs_req, obs_addr);
    end
    for (int c = 0; c < 20 && !done; c++) begin
      drive_cycle(1'b1, 32'h0, 1'b1);
      if (obs_stall !== 1'b1) done = 1;
    end
    n_checks++;
    if (obs_inst !== 32'h11 || obs_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_fill: inst=%h stall=%b, wanted 00000011 and 0", obs_inst, obs_stall);
    end
    drive_cycle(1'b1, 32'h204, 1'b0);
    n_checks++;
    if (obs_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_line_valid: stall=%b, wanted 1", obs_stall);
    end
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      drive_cycle(1'b1, 32'h204, 1'b1);
      if (obs_stall !== 1'b1) done = 1;
    end
  endtask

  task automatic test_chip_disable();
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, $urandom, 1'($urandom_range(0, 1)));
      n_checks++;
      if (obs_stall !== 1'b0 || obs_inst !== 32'h0 || obs_req !== 1'b0) begin
        n_fail++;
        $display("FAIL chip_disable k%0d: stall=%b inst=%h req=%b, wanted 0/0/0", k, obs_stall, obs_inst, obs_req);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit ce;
    int errs = 0;
    for (int k = 0; k < 400; k++) begin
      a  = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      ce = ($urandom_range(0, 7) != 0);
      drive_cycle(ce, a, 1'($urandom_range(0, 1)));
      n_checks++;
      if (obs_stall !== exp_stall || obs_inst !== exp_inst || obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random k%0d a=%h: stall=%b inst=%h req=%b addr=%h, wanted stall=%b inst=%h req=%b addr=%h",
                   k, a, obs_stall, obs_inst, obs_req, obs_addr, exp_stall, exp_inst, exp_req, exp_addr);
        errs++;
      end
    end
`ifdef ICACHE_STATS_EN
    n_checks++;
    if (o_hitCount !== mdl_hits || o_missCount !== mdl_misses) begin
      n_fail++;
      $display("FAIL stats_random: hit=%0d miss=%0d, wanted %0d and %0d", o_hitCount, o_missCount, mdl_hits, mdl_misses);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_conflict();
    test_slow_mem();
    test_reset_mid_refill();
    test_chip_disable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
